// File: rtl/branch_predictor.sv
// Tagged branch target buffer with per-entry saturating direction counters and
// an optional non-speculative gshare history folded into the query index.
module branch_predictor #(
  parameter int unsigned ENTRY_BITS = 6,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned GHR_BITS   = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  query_valid_in,
  input  logic [31:0]           query_pc_in,
  output logic                  pred_valid_out,
  output logic                  pred_taken_out,
  output logic                  pred_hit_out,
  output logic [31:0]           pred_target_out,
  output logic [ENTRY_BITS-1:0] pred_idx_out,
  input  logic                  upd_valid_in,
  input  logic [31:0]           upd_pc_in,
  input  logic [ENTRY_BITS-1:0] upd_idx_in,
  input  logic                  upd_taken_in,
  input  logic [31:0]           upd_target_in
);

  localparam int unsigned N      = 1 << ENTRY_BITS;
  localparam int unsigned GW     = (GHR_BITS == 0) ? 1 : GHR_BITS;
  localparam int unsigned TAG_LO = ENTRY_BITS + 2;
  localparam int unsigned TAG_HI = ENTRY_BITS + TAG_BITS + 1;

  localparam logic [CNT_WIDTH-1:0] CNT_WT  = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_WNT = ~CNT_WT;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                  tbl_valid  [N];
  logic [TAG_BITS-1:0]   tbl_tag    [N];
  logic [CNT_WIDTH-1:0]  tbl_cnt    [N];
  logic [31:0]           tbl_target [N];

  logic [GW-1:0]         ghr;
  logic [GW-1:0]         ghr_next;
  logic [ENTRY_BITS-1:0] ghr_ext;
  logic [ENTRY_BITS-1:0] q_idx;
  logic [TAG_BITS-1:0]   q_tag;
  logic                  q_hit;
  logic                  q_taken;
  logic [31:0]           q_target;
  logic [TAG_BITS-1:0]   u_tag;
  logic                  u_hit;
  logic [CNT_WIDTH-1:0]  u_cnt;
  logic [CNT_WIDTH-1:0]  u_cnt_next;
  logic                  unused_upd_pc;

  assign unused_upd_pc = ^{upd_pc_in[31:TAG_HI+1], upd_pc_in[TAG_LO-1:0]};

  // Query side reads the table as it stands before this cycle's update.
  always_comb begin
    ghr_ext          = '0;
    ghr_ext[GW-1:0]  = ghr;
    q_idx            = query_pc_in[ENTRY_BITS+1:2] ^ ghr_ext;
    q_tag            = query_pc_in[TAG_HI:TAG_LO];
    q_hit            = tbl_valid[q_idx] && (tbl_tag[q_idx] == q_tag);
    q_taken          = q_hit && tbl_cnt[q_idx][CNT_WIDTH-1];
    q_target         = q_taken ? tbl_target[q_idx] : query_pc_in + 32'd4;
  end

  always_comb begin
    u_tag      = upd_pc_in[TAG_HI:TAG_LO];
    u_cnt      = tbl_cnt[upd_idx_in];
    u_hit      = tbl_valid[upd_idx_in] && (tbl_tag[upd_idx_in] == u_tag);
    u_cnt_next = u_cnt;
    if (!u_hit) begin
      u_cnt_next = upd_taken_in ? CNT_WT : CNT_WNT;
    end else if (upd_taken_in) begin
      if (u_cnt != '1) u_cnt_next = u_cnt + CNT_ONE;
    end else begin
      if (u_cnt != '0) u_cnt_next = u_cnt - CNT_ONE;
    end
    // Bimodal builds keep a single constant-zero history bit.
    ghr_next = (GHR_BITS == 0) ? '0 : GW'({ghr, upd_taken_in});
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < N; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_cnt[i]    <= CNT_WNT;
        tbl_target[i] <= '0;
      end
      ghr             <= '0;
      pred_valid_out  <= 1'b0;
      pred_taken_out  <= 1'b0;
      pred_hit_out    <= 1'b0;
      pred_target_out <= '0;
      pred_idx_out    <= '0;
    end else if (rdy_in) begin
      pred_valid_out <= query_valid_in;
      if (query_valid_in) begin
        pred_taken_out  <= q_taken;
        pred_hit_out    <= q_hit;
        pred_target_out <= q_target;
        pred_idx_out    <= q_idx;
      end
      if (upd_valid_in) begin
        tbl_valid[upd_idx_in] <= 1'b1;
        tbl_tag[upd_idx_in]   <= u_tag;
        tbl_cnt[upd_idx_in]   <= u_cnt_next;
        if (!u_hit || upd_taken_in) tbl_target[upd_idx_in] <= upd_target_in;
        ghr <= ghr_next;
      end
    end
  end

endmodule
